adder_tree_pipe: RTL and testbench

ADDER_TREE_PIPE -- requirements
Module: adder_tree_pipe

---
 rtl/adder_tree_pipe.sv | 147 ++++++++++++++
 tb/tb_adder_tree_pipe.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_pipe.sv
// adder_tree_pipe: pipelined signed adder tree, N_IN addends of DW bits -> OW-bit sum.
// One register level per tree level (LAT = clog2(N_IN)), the last level also does the
// IW->OW reduction. Optional saturation: define ADDER_TREE_SAT_EN to clamp and flag ovf;
// without it the result wraps and ovf stays 0.

// One tree node: registered pair sum, or registered pass-through of an odd leftover.
module adder_tree_node #(
  parameter int W    = 15,
  parameter bit PAIR = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] s
);

  // rst > clr > en; the width is wide enough that the sum is exact
  always_ff @(posedge clk) begin
    if (rst)      s <= '0;
    else if (clr) s <= '0;
    else if (en)  s <= PAIR ? a + b : a;
  end

endmodule

module adder_tree_pipe #(
  parameter int N_IN = 6,
  parameter int DW   = 12,
  parameter int OW   = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 valid_in,
  input  logic [N_IN*DW-1:0]   datain,
  output logic                 valid_out,
  output logic [OW-1:0]        dataout,
  output logic                 ovf
);

  localparam int LAT = $clog2(N_IN);
  localparam int IW  = DW + LAT;

  // operand count at tree level j (level 0 = the raw addends)
  function automatic int cnt_at(input int j);
    return (N_IN + (1 << j) - 1) >> j;
  endfunction

  // Levels 0..LAT-1 of the tree. Level 0 is the sign-extended input (no register);
  // levels 1..LAT-1 are registered nodes. The final pair is summed in the output stage.
  for (genvar j = 0; j < LAT; j++) begin : lvl_g
    for (genvar k = 0; k < cnt_at(j); k++) begin : nd_g
      logic signed [IW-1:0] s;
      if (j == 0) begin : in_g
        assign s = IW'(signed'(datain[k*DW +: DW]));
      end else if (2*k+1 < cnt_at(j-1)) begin : pair_g
        adder_tree_node #(.W(IW), .PAIR(1'b1)) u_node (
          .clk (clk),
          .rst (rst),
          .clr (clr),
          .en  (en),
          .a   (lvl_g[j-1].nd_g[2*k].s),
          .b   (lvl_g[j-1].nd_g[2*k+1].s),
          .s   (s)
        );
      end else begin : pass_g
        adder_tree_node #(.W(IW), .PAIR(1'b0)) u_node (
          .clk (clk),
          .rst (rst),
          .clr (clr),
          .en  (en),
          .a   (lvl_g[j-1].nd_g[2*k].s),
          .b   ('0),
          .s   (s)
        );
      end
    end
  end

  // Level LAT-1 always holds exactly two operands; their sum is the full-precision result.
  logic signed [IW-1:0] fin;
  assign fin = lvl_g[LAT-1].nd_g[0].s + lvl_g[LAT-1].nd_g[1].s;

  logic signed [OW-1:0] red;
  logic                 red_ovf;

  if (OW >= IW) begin : sext_g
    // result always fits: plain sign extension
    assign red     = OW'(fin);
    assign red_ovf = 1'b0;
  end else begin : narrow_g
`ifdef ADDER_TREE_SAT_EN
    localparam logic signed [IW-1:0] SMAX = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [IW-1:0] SMIN = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};
    // clamp to the OW signed range and flag when clamping happened
    always_comb begin
      red     = OW'(fin);
      red_ovf = 1'b0;
      if (fin > SMAX) begin
        red     = OW'(SMAX);
        red_ovf = 1'b1;
      end else if (fin < SMIN) begin
        red     = OW'(SMIN);
        red_ovf = 1'b1;
      end
    end
`else
    // wrap-around: keep the low OW bits
    assign red     = fin[OW-1:0];
    assign red_ovf = 1'b0;
`endif
  end

  // Output stage: registered reduced sum and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      dataout <= '0;
      ovf     <= 1'b0;
    end else if (clr) begin
      dataout <= '0;
      ovf     <= 1'b0;
    end else if (en) begin
      dataout <= red;
      ovf     <= red_ovf;
    end
  end

  // Valid shift register travelling alongside the data levels
  logic [LAT:1] vld_pipe;
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else if (clr) begin
      vld_pipe <= '0;
    end else if (en) begin
      vld_pipe[1] <= valid_in;
      for (int i = 2; i <= LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign valid_out = vld_pipe[LAT];

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Scoreboard bench for adder_tree_pipe (N_IN=6, DW=12, OW=12): directed cases plus random traffic.
module tb_adder_tree_pipe;
  localparam int N_IN = 6;
  localparam int DW   = 12;
  localparam int OW   = 12;
  localparam int LAT  = 3;

  logic               clk = 1'b0;
  logic               rst, en, clr, valid_in;
  logic [N_IN*DW-1:0] datain;
  logic               valid_out;
  logic [OW-1:0]      dataout;
  logic               ovf;

  adder_tree_pipe #(.N_IN(N_IN), .DW(DW), .OW(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .valid_in  (valid_in),
    .datain    (datain),
    .valid_out (valid_out),
    .dataout   (dataout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] d;
    logic          o;
    int            tag;
  } exp_t;

  exp_t sb[$];
  int   ecnt   = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // reference: integer sum of the channels, then clamp or wrap into OW bits
  function automatic exp_t model(input logic [N_IN*DW-1:0] d, input int tag);
    exp_t e;
    int s, r;
    logic signed [DW-1:0] ch;
    s = 0;
    for (int k = 0; k < N_IN; k++) begin
      ch = d[k*DW +: DW];
      s += int'(ch);
    end
    r   = s;
    e.o = 1'b0;
`ifdef ADDER_TREE_SAT_EN
    if (s > (1 << (OW-1)) - 1) begin
      r = (1 << (OW-1)) - 1; e.o = 1'b1;
    end else if (s < -(1 << (OW-1))) begin
      r = -(1 << (OW-1)); e.o = 1'b1;
    end
`endif
    e.d   = r[OW-1:0];
    e.tag = tag;
    return e;
  endfunction

  function automatic logic [N_IN*DW-1:0] pk_all(input int v);
    logic [N_IN*DW-1:0] r;
    for (int k = 0; k < N_IN; k++) r[k*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [N_IN*DW-1:0] pk_seq();
    logic [N_IN*DW-1:0] r;
    for (int k = 0; k < N_IN; k++) r[k*DW +: DW] = DW'(k + 1);
    return r;
  endfunction

  function automatic logic [N_IN*DW-1:0] rnd_vec();
    logic [N_IN*DW-1:0] r;
    int mode;
    mode = $urandom_range(0, 3);
    for (int k = 0; k < N_IN; k++) begin
      if (mode == 0)      r[k*DW +: DW] = DW'(2047 - $urandom_range(0, 200));
      else if (mode == 1) r[k*DW +: DW] = DW'(-2048 + $urandom_range(0, 200));
      else                r[k*DW +: DW] = DW'($urandom);
    end
    return r;
  endfunction

  // one clock cycle of stimulus; records the expected result of an accepted vector
  task automatic cyc(input logic r, input logic c, input logic e, input logic v,
                     input logic [N_IN*DW-1:0] d);
    rst = r; clr = c; en = e; valid_in = v; datain = d;
    if (r || c) sb.delete();
    else if (e && v) sb.push_back(model(d, ecnt));
    @(posedge clk);
    if (!r && !c && e) ecnt++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd_vec());
  endtask

  // monitor: outputs held during stalls, and each consumed output matches the scoreboard
  logic          pv, po;
  logic [OW-1:0] pd;
  bit            pstall = 1'b0;
  exp_t          me;
  always @(negedge clk) begin
    if (pstall) chk("stall_hold", {valid_out, dataout, ovf}, {pv, pd, po});
    pstall = (rst === 1'b0 && clr === 1'b0 && en === 1'b0);
    pv = valid_out; pd = dataout; po = ovf;
    if (rst === 1'b0 && clr === 1'b0 && en === 1'b1 && valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 64'd1, 64'd0);
      end else begin
        me = sb.pop_front();
        chk("dataout", 64'(dataout), 64'(me.d));
        chk("ovf", 64'(ovf), 64'(me.o));
        chk("latency", 64'(ecnt - me.tag), 64'(LAT));
      end
    end
  end

  logic rr, rc, re, rv;
  initial begin
    rst = 1'b1; clr = 1'b0; en = 1'b1; valid_in = 1'b0; datain = '0;
    repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0, '0);
    chk("reset_valid_out", 64'(valid_out), 64'd0);
    chk("reset_dataout", 64'(dataout), 64'd0);
    chk("reset_ovf", 64'(ovf), 64'd0);

    // 1..6 -> 21; extremes
    cyc(1'b0, 1'b0, 1'b1, 1'b1, pk_seq());
    idle(5);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, pk_all(2047));
    idle(5);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, pk_all(-2048));
    idle(5);

    // back-to-back A/B then a two-cycle stall
    cyc(1'b0, 1'b0, 1'b1, 1'b1, pk_all(1));
    cyc(1'b0, 1'b0, 1'b1, 1'b1, pk_all(-1));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, rnd_vec());
    cyc(1'b0, 1'b0, 1'b0, 1'b0, rnd_vec());
    idle(5);

    // flush one cycle after a vector, by rst then by clr, then all-10 -> 60
    cyc(1'b0, 1'b0, 1'b1, 1'b1, pk_all(7));
    cyc(1'b1, 1'b0, 1'b1, 1'b0, rnd_vec());
    cyc(1'b0, 1'b0, 1'b1, 1'b1, pk_all(10));
    idle(5);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, pk_all(7));
    cyc(1'b0, 1'b1, 1'b1, 1'b0, rnd_vec());
    cyc(1'b0, 1'b0, 1'b1, 1'b1, pk_all(10));
    idle(5);

    // clr while stalled still flushes
    cyc(1'b0, 1'b0, 1'b1, 1'b1, pk_all(3));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, rnd_vec());
    cyc(1'b0, 1'b1, 1'b0, 1'b0, rnd_vec());
    idle(5);

    // random traffic with stalls, clears and occasional reset
    for (int i = 0; i < 600; i++) begin
      rr = ($urandom_range(0, 99) == 0);
      rc = ($urandom_range(0, 49) == 0);
      re = ($urandom_range(0, 9) != 0);
      rv = ($urandom_range(0, 2) != 0);
      cyc(rr, rc, re, rv, rnd_vec());
    end
    idle(6);
    chk("drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
